// File: rtl/sar_sched_pkg.sv
// sar_sched_pkg: shared sizes, FSM states and channel-pick helper for the SAR scheduler
package sar_sched_pkg;
  localparam int SAR_W = 10;
  localparam int CH_W = 2;
  localparam int NCH = 4;
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONV, CAPTURE} state_t;
  function automatic logic [CH_W-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) if (m[i]) lowest = CH_W'(i);
  endfunction
endpackage

// File: rtl/sar_sched_timer.sv
// sar_sched_timer: scan period down-counter, one-cycle tick at zero, held at period-1 while disabled
module sar_sched_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] period,
  output logic        tick
);
  logic [15:0] cnt, top;
  assign top = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign tick = rst && en && cnt == 16'd0;
  always_ff @(posedge clk)
    cnt <= (!rst || !en || cnt == 16'd0) ? top : cnt - 16'd1;
endmodule

// File: rtl/sar_conv_scheduler.sv
// sar_conv_scheduler: periodic masked-channel SAR scan sequencer with sticky error flags
// SAR_SCHED_AVG_EN: convert each channel 4x back-to-back and report the mean
module sar_conv_scheduler
  import sar_sched_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      period,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             err_clr,
  input  logic             eoc,
  input  logic [SAR_W-1:0] sar,
  output logic             cnvst,
  output logic [CH_W-1:0]  ch_sel,
  output logic [SAR_W-1:0] dout,
  output logic [CH_W-1:0]  dout_ch,
  output logic             dout_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err
);
`ifdef SAR_SCHED_AVG_EN
  localparam int ACC_W = SAR_W + 2;
  logic [1:0] k;
`else
  localparam int ACC_W = SAR_W;
`endif
  state_t state, nxt, fin;
  logic tick, to_hit, last, to_q, ov_q;
  logic [NCH-1:0] rem, src;
  logic [CH_W-1:0] ch, ch_nxt;
  logic [15:0] cnt;
  logic [ACC_W-1:0] acc;

  sar_sched_timer u_timer (.clk(clk), .rst(rst), .en(en), .period(period), .tick(tick));

  assign to_hit = state == CONV && !eoc && cnt == 16'(TIMEOUT_CYC - 1);
  assign fin = (|rem && en) ? SELECT : IDLE;
  assign src = (state == IDLE) ? ch_mask : rem;
  assign ch_nxt = lowest(src);
`ifdef SAR_SCHED_AVG_EN
  assign last = k == 2'd0;
`else
  assign last = 1'b1;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (tick && |ch_mask) ? SELECT : IDLE;
      SELECT:  nxt = SETTLE;
      SETTLE:  nxt = (cnt == 16'(SETTLE_CYC - 1)) ? CONV : SETTLE;
      CONV:    nxt = eoc ? CAPTURE : to_hit ? fin : CONV;
      CAPTURE: nxt = last ? fin : CONV;
      default: nxt = IDLE;
    endcase
  end

  // rem holds the latched mask minus channels already picked this scan
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rem <= '0;
      ch <= '0;
      cnt <= '0;
      acc <= '0;
      to_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef SAR_SCHED_AVG_EN
      k <= '0;
`endif
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? 16'd0 : cnt + 16'd1;
      if (nxt == SELECT) begin
        ch <= ch_nxt;
        rem <= src & ~(NCH'(1) << ch_nxt);
        acc <= '0;
`ifdef SAR_SCHED_AVG_EN
        k <= '0;
`endif
      end
      if (state == CONV && eoc) begin
`ifdef SAR_SCHED_AVG_EN
        acc <= acc + ACC_W'(sar);
        k <= k + 2'd1;
`else
        acc <= sar;
`endif
      end
      to_q <= to_hit | (to_q & ~err_clr);
      ov_q <= (tick && state != IDLE) | (ov_q & ~err_clr);
    end
  end

  assign cnvst = rst && state == CONV;
  assign busy = rst && state != IDLE;
  assign ch_sel = rst ? ch : '0;
  assign dout_ch = rst ? ch : '0;
  assign dout_valid = rst && state == CAPTURE && last;
  assign dout = rst ? acc[ACC_W-1 -: SAR_W] : '0;
  assign timeout_err = rst && to_q;
  assign overrun_err = rst && ov_q;
endmodule

// File: tb/tb_sar_conv_scheduler.sv
// tb_sar_conv_scheduler: randomized scoreboard bench with a SAR responder model for sar_conv_scheduler
`timescale 1ns/1ps
module tb_sar_conv_scheduler;
  logic clk = 0, rst = 0, en = 0, err_clr = 0, eoc = 0;
  logic [15:0] period = 16'd100;
  logic [3:0] ch_mask = 4'd0;
  logic [9:0] sar = 10'd0;
  logic cnvst, dout_valid, busy, timeout_err, overrun_err;
  logic [1:0] ch_sel, dout_ch;
  logic [9:0] dout;
  int errors = 0, checks = 0;
`ifdef SAR_SCHED_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  typedef struct {logic [1:0] ch; logic [9:0] v; int dly; int kind;} conv_t;
  typedef struct {logic [1:0] ch; logic [9:0] v;} res_t;
  conv_t sar_q[$];
  res_t exp_q[$];

  sar_conv_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .ch_mask(ch_mask), .err_clr(err_clr),
    .eoc(eoc), .sar(sar), .cnvst(cnvst), .ch_sel(ch_sel), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_conv(input logic [1:0] ch, input logic [9:0] v, input int dly, input int kind);
    conv_t c;
    c.ch = ch; c.v = v; c.dly = dly; c.kind = kind;
    sar_q.push_back(c);
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [9:0] v);
    res_t r;
    r.ch = ch; r.v = v;
    exp_q.push_back(r);
  endtask

  // kind 0: answers after dly cycles, 1: never answers, 2: cut short by reset
  task automatic plan_scan(input logic [3:0] m, input logic [3:0] tm, input bit rnd_idx);
    int sum, ti, v;
    for (int i = 0; i < 4; i++) if (m[i]) begin
      ti = !tm[i] ? NCONV : rnd_idx ? int'($urandom_range(NCONV - 1)) : 0;
      sum = 0;
      for (int k = 0; k < NCONV && k <= ti; k++) begin
        v = int'($urandom_range(1023));
        push_conv(2'(i), 10'(v), int'($urandom_range(10, 1)), (k == ti) ? 1 : 0);
        sum += v;
      end
      if (ti == NCONV) push_exp(2'(i), 10'(sum / NCONV));
    end
  endtask

  task automatic wait_busy(input logic v, input int lim);
    int n = 0;
    while (busy !== v && n < lim) begin @(negedge clk); n++; end
    chk("busy_wait", busy, v);
  endtask

  task automatic wait_cnvst(input int lim);
    int n = 0;
    while (cnvst !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    chk("cnvst_wait", cnvst, 1);
  endtask

  task automatic drained();
    chk("sar_q_drained", sar_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic scan_go(input logic [15:0] p, input logic [3:0] m);
    period = p;
    ch_mask = m;
    @(negedge clk);
    en = 1;
    wait_busy(1, int'(p) + 20);
    ch_mask = 4'($urandom);
    wait_busy(0, 5000);
    en = 0;
    drained();
  endtask

  task automatic run_scan(input logic [15:0] p, input logic [3:0] m, input logic [3:0] tm, input bit rnd_idx);
    plan_scan(m, tm, rnd_idx);
    scan_go(p, m);
  endtask

  task automatic all_zero(input string pfx);
    chk({pfx, "cnvst"}, cnvst, 0);
    chk({pfx, "ch_sel"}, ch_sel, 0);
    chk({pfx, "dout"}, dout, 0);
    chk({pfx, "dout_ch"}, dout_ch, 0);
    chk({pfx, "dout_valid"}, dout_valid, 0);
    chk({pfx, "busy"}, busy, 0);
    chk({pfx, "timeout_err"}, timeout_err, 0);
    chk({pfx, "overrun_err"}, overrun_err, 0);
  endtask

  initial begin : responder
    conv_t c;
    int n;
    forever begin
      @(negedge clk);
      if (cnvst === 1'b1) begin
        if (sar_q.size() == 0) begin
          chk("unexpected_cnvst", 1, 0);
          n = 0;
          while (cnvst === 1'b1 && n < 200) begin n++; @(negedge clk); end
        end else begin
          c = sar_q.pop_front();
          chk("conv_ch", ch_sel, c.ch);
          if (c.kind == 0) begin
            repeat (c.dly) @(negedge clk);
            chk("cnvst_hold", cnvst, 1);
            eoc = 1;
            sar = c.v;
            @(negedge clk);
            eoc = 0;
            sar = 10'($urandom);
            chk("cnvst_drop", cnvst, 0);
          end else begin
            n = 0;
            while (cnvst === 1'b1 && n < 200) begin n++; @(negedge clk); end
            if (c.kind == 1) chk("cnvst_high_cycles", n, 64);
          end
        end
      end
    end
  end

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_dout_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dout", dout, e.v);
          chk("dout_ch", dout_ch, e.ch);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    all_zero("reset_");
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", busy, 0);
    for (int k = 0; k < NCONV; k++) push_conv(2'd0, 10'h155, 3, 0);
    for (int k = 0; k < NCONV; k++) push_conv(2'd2, 10'h2AA, 3, 0);
    push_exp(2'd0, 10'h155);
    push_exp(2'd2, 10'h2AA);
    scan_go(16'd100, 4'b0101);
    chk("basic_timeout_err", timeout_err, 0);
    chk("basic_overrun_err", overrun_err, 0);
`ifdef SAR_SCHED_AVG_EN
    for (int k = 0; k < 4; k++) push_conv(2'd1, 10'(100 + k), 2, 0);
    push_exp(2'd1, 10'd101);
    scan_go(16'd100, 4'b0010);
`endif
    period = 16'd10;
    ch_mask = 4'd0;
    @(negedge clk);
    en = 1;
    n = 0;
    repeat (40) begin @(negedge clk); if (busy !== 1'b0) n++; end
    en = 0;
    chk("mask0_ignored", n, 0);
    run_scan(16'd0, 4'($urandom_range(15, 1)), 4'd0, 1);
    run_scan(16'd1, 4'($urandom_range(15, 1)), 4'd0, 1);
    for (int r = 0; r < 10; r++)
      run_scan(16'($urandom_range(200)), 4'($urandom_range(15, 1)), 4'($urandom & $urandom & $urandom), 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_pre_timeout", timeout_err, 0);
    run_scan(16'd100, 4'b0011, 4'b0001, 0);
    chk("timeout_set", timeout_err, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr_alone_to", timeout_err, 0);
    chk("err_clr_alone_ov", overrun_err, 0);
    plan_scan(4'b0001, 4'b0001, 0);
    period = 16'd50;
    ch_mask = 4'b0001;
    @(negedge clk);
    en = 1;
    wait_busy(1, 80);
    wait_cnvst(20);
    repeat (63) @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_vs_set", timeout_err, 1);
    wait_busy(0, 5000);
    en = 0;
    drained();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_after_set", timeout_err, 0);
    run_scan(16'd5, 4'hF, 4'd0, 0);
    chk("overrun_set", overrun_err, 1);
    plan_scan(4'b0001, 4'd0, 0);
    period = 16'd30;
    ch_mask = 4'hF;
    @(negedge clk);
    en = 1;
    wait_busy(1, 60);
    wait_cnvst(20);
    en = 0;
    wait_busy(0, 5000);
    drained();
    push_conv(2'd0, 10'd0, 0, 2);
    period = 16'd20;
    ch_mask = 4'b0001;
    @(negedge clk);
    en = 1;
    wait_busy(1, 40);
    wait_cnvst(20);
    rst = 0;
    en = 0;
    @(negedge clk);
    all_zero("rst_conv_");
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst_conv", busy, 0);
    drained();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sar_conv_scheduler.md
SAR_CONV_SCHEDULER -- requirements
Module: sar_conv_scheduler

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles from ch_sel change to cnvst assertion (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 64: cycles cnvst may stay high without eoc before abort.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 en  in  1  scan enable.
REQ-006 period  in  16  cycles between scan starts; 0 is treated as 1.
REQ-007 ch_mask  in  4  enabled analog channels.
REQ-008 err_clr  in  1  clears sticky error flags.
REQ-009 eoc  in  1  end of conversion from SAR logic.
REQ-010 sar  in  10  SAR result, valid while eoc is high.
REQ-011 cnvst  out  1  conversion start to SAR logic.
REQ-012 ch_sel  out  2  analog mux select.
REQ-013 dout, dout_ch, dout_valid  out  10, 2, 1  result, its channel, one-cycle valid strobe.
REQ-014 busy, timeout_err, overrun_err  out  1 each  scan active, sticky eoc timeout, sticky missed tick.

Function
REQ-015 Period timer SHALL run while en=1, reload to period-1 after reaching 0, and emit a one-cycle tick at 0.
REQ-016 Period timer SHALL hold at period-1 while en=0.
REQ-017 FSM states SHALL be IDLE, SELECT, SETTLE, CONV, CAPTURE.
REQ-018 IDLE->SELECT on tick with en=1 and ch_mask!=0; ch_mask SHALL be latched at this transition.
REQ-019 Tick with ch_mask=0 SHALL be ignored.
REQ-020 SELECT (1 cycle) SHALL drive ch_sel to the lowest unconverted channel in the latched mask.
REQ-021 SELECT SHALL then go to SETTLE, which lasts exactly SETTLE_CYC cycles.
REQ-022 In CONV, cnvst SHALL be 1 and SHALL stay 1 until eoc=1 is sampled or TIMEOUT_CYC cycles have elapsed.
REQ-023 On eoc=1 in CONV, cnvst SHALL drop on the next cycle and CAPTURE SHALL register sar.
REQ-024 dout_valid SHALL pulse for 1 cycle with dout and dout_ch stable during that cycle.
REQ-025 On timeout, cnvst SHALL drop, timeout_err SHALL set, no dout_valid SHALL be emitted, and the FSM SHALL advance to the next channel.
REQ-026 After a channel completes, the FSM SHALL go to SELECT if unconverted masked channels remain and en=1; otherwise IDLE.
REQ-027 en deasserted mid-scan SHALL let the current conversion finish, then end the scan.
REQ-028 A tick while not IDLE SHALL set overrun_err and SHALL be dropped (no queueing).
REQ-029 err_clr SHALL clear both sticky errors.
REQ-030 A set event and err_clr in the same cycle SHALL leave the flag set.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 ch_sel SHALL be stable from SELECT through CAPTURE.

Reset
REQ-033 rst=0 SHALL force IDLE and reload the timer to period-1.
REQ-034 During rst=0, all outputs SHALL be 0 (cnvst, ch_sel, dout, dout_ch, dout_valid, busy, timeout_err, overrun_err), including mid-conversion.

Configuration
REQ-035 With SAR_SCHED_AVG_EN defined, each channel SHALL be converted 4 times back-to-back (SETTLE only before the first), summed in 12 bits, and reported as dout = sum>>2 with one dout_valid.
REQ-036 With SAR_SCHED_AVG_EN defined, any timeout within the 4 conversions SHALL discard that channel's result.
REQ-037 Without SAR_SCHED_AVG_EN, each channel SHALL be converted once and reported unmodified.

Structure
REQ-038 Package sar_sched_pkg SHALL hold the FSM state enum, SAR_W=10, CH_W=2 and NCH=4.
REQ-039 Sub-module sar_sched_timer SHALL implement the period counter and tick.

Verification
REQ-040 Reset and scan: period=100, ch_mask=4'b0101, eoc returned 3 cycles after cnvst rises with sar=10'h155 then 10'h2AA -> dout_valid twice: ch 0 with 10'h155, ch 2 with 10'h2AA; busy then drops.
REQ-041 Timeout: eoc never asserted, TIMEOUT_CYC=64 -> cnvst high exactly 64 cycles, timeout_err=1, no dout_valid, next channel still converted.
REQ-042 Overrun: period=5, ch_mask=4'hF, SETTLE_CYC=4 -> overrun_err=1, no scan restarted mid-scan.
REQ-043 Reset mid-CONV: rst=0 while cnvst=1 -> next cycle all outputs 0, state IDLE.
REQ-044 With SAR_SCHED_AVG_EN defined: sar sequence 10'd100, 101, 102, 103 on ch 1 -> one dout_valid with dout=10'd101.
REQ-045 err_clr: err_clr=1 coincident with a new timeout -> timeout_err remains 1; err_clr alone -> 0.
